timebase_label_renderer: RTL



---
 rtl/timebase_pkg.sv | 49 ++++
 rtl/timebase_label_renderer_if.sv | 25 ++
 rtl/label_font_rom.sv | 43 ++++
 rtl/timebase_label_renderer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// Shared definitions for the timebase label overlay: character codes, label strings, glyph geometry.
// Latency: none (constants and types only).
// Backpressure: none.
package timebase_pkg;

    localparam int GLYPH_W    = 5;   // lit columns per character cell
    localparam int GLYPH_H    = 11;  // rows per glyph
    localparam int CELL_PITCH = 6;   // glyph columns plus one blank column
    localparam int NUM_CELLS  = 6;   // characters per label

    typedef enum logic [3:0] {
        CH_0     = 4'd0,
        CH_1     = 4'd1,
        CH_2     = 4'd2,
        CH_3     = 4'd3,
        CH_4     = 4'd4,
        CH_5     = 4'd5,
        CH_6     = 4'd6,
        CH_7     = 4'd7,
        CH_8     = 4'd8,
        CH_9     = 4'd9,
        CH_DOT   = 4'd10,
        CH_m     = 4'd11,
        CH_S     = 4'd12,
        CH_SPACE = 4'd13
    } char_code_t;

    // One row per timebase setting, slot 0 is the leftmost character.
    // Unused settings render as blanks.
    localparam logic [3:0] LABEL_TABLE [0:15][0:NUM_CELLS-1] = '{
        '{CH_0, CH_DOT, CH_1, CH_SPACE, CH_m, CH_S},      // "0.1 mS"
        '{CH_0, CH_DOT, CH_2, CH_SPACE, CH_m, CH_S},      // "0.2 mS"
        '{CH_0, CH_DOT, CH_5, CH_SPACE, CH_m, CH_S},      // "0.5 mS"
        '{CH_1, CH_DOT, CH_0, CH_SPACE, CH_m, CH_S},      // "1.0 mS"
        '{CH_2, CH_DOT, CH_0, CH_SPACE, CH_m, CH_S},      // "2.0 mS"
        '{CH_5, CH_DOT, CH_0, CH_SPACE, CH_m, CH_S},      // "5.0 mS"
        '{CH_1, CH_0, CH_SPACE, CH_m, CH_S, CH_SPACE},    // "10 mS "
        '{CH_5, CH_0, CH_SPACE, CH_m, CH_S, CH_SPACE},    // "50 mS "
        '{default: CH_SPACE},
        '{default: CH_SPACE},
        '{default: CH_SPACE},
        '{default: CH_SPACE},
        '{default: CH_SPACE},
        '{default: CH_SPACE},
        '{default: CH_SPACE},
        '{default: CH_SPACE}
    };

endpackage

// File: rtl/timebase_label_renderer_if.sv
// Overlay bus between the VGA timing/front-panel logic and the timebase label renderer.
// Latency: n/a (wires only); PIXEL_ON trails the coordinates by two clocks inside the renderer.
// Backpressure: none, the pixel stream is free-running.
interface timebase_label_renderer_if #(
    parameter int COORD_W = 12
);
    logic [COORD_W-1:0] VGA_horzCoord;
    logic [COORD_W-1:0] VGA_vertCoord;
    logic               FRAME_START;
    logic               STEP_UP;
    logic               STEP_DOWN;
    logic [3:0]         SETTING;
    logic               PIXEL_ON;
    logic               HIGHLIGHT;

    modport master (
        output VGA_horzCoord, VGA_vertCoord, FRAME_START, STEP_UP, STEP_DOWN,
        input  SETTING, PIXEL_ON, HIGHLIGHT
    );

    modport slave (
        input  VGA_horzCoord, VGA_vertCoord, FRAME_START, STEP_UP, STEP_DOWN,
        output SETTING, PIXEL_ON, HIGHLIGHT
    );
endinterface

// File: rtl/label_font_rom.sv
// 5x11 bitmap font for digits, '.', 'm', 'S' and space; returns one pixel.
// Latency: combinational.
// Backpressure: none.
module label_font_rom
    import timebase_pkg::*;
(
    input  logic [3:0] i_char_code,
    input  logic [3:0] i_row,
    input  logic [2:0] i_col,
    output logic       o_pixel
);

    // Bit 4 of each row is the leftmost column of the glyph.
    localparam logic [4:0] FONT [0:13][0:GLYPH_H-1] = '{
        '{5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11111}, // 0
        '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000}, // 1
        '{5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b11111, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111}, // 2
        '{5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b11111}, // 3
        '{5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001}, // 4
        '{5'b11111, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b11111}, // 5
        '{5'b11111, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11111}, // 6
        '{5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001}, // 7
        '{5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11111}, // 8
        '{5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b11111}, // 9
        '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b01100, 5'b01100}, // .
        '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11110, 5'b10101, 5'b10101, 5'b10101, 5'b10101, 5'b10101, 5'b10101}, // m
        '{5'b01111, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b11110}, // S
        '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000}  // space
    };

    logic [4:0] w_bits;

    // Fetch the glyph row; unknown codes and rows below the glyph are blank.
    always_comb begin
        w_bits = 5'b00000;
        if ((i_char_code <= CH_SPACE) && (i_row < 4'(GLYPH_H))) begin
            w_bits = FONT[i_char_code][i_row];
        end
    end

    assign o_pixel = (i_col < 3'(GLYPH_W)) ? w_bits[3'(GLYPH_W - 1) - i_col] : 1'b0;

endmodule

// File: rtl/timebase_label_renderer.sv
// Holds the timebase setting and renders its label as a glyph overlay at (X0,Y0), scaled by SCALE.
// Latency: PIXEL_ON is exactly 2 CLK after the coordinates; SETTING/HIGHLIGHT update on FRAME_START.
// Backpressure: none, one pixel accepted every clock.
module timebase_label_renderer
    import timebase_pkg::*;
#(
    parameter int X0            = 243,
    parameter int Y0            = 940,
    parameter int SCALE         = 1,
    parameter int NUM_SETTINGS  = 8,
    parameter int RESET_SETTING = 0,
    parameter int FLASH_FRAMES  = 30,
    parameter int COORD_W       = 12
)(
    input  logic                       CLK,
    input  logic                       RESETn,
    timebase_label_renderer_if.slave   bus
);

    localparam int SH    = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);
    localparam int REG_W = NUM_CELLS * CELL_PITCH * SCALE;
    localparam int REG_H = GLYPH_H * SCALE;
    localparam int FW    = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

    localparam logic [3:0]    MAX_IDX    = 4'(NUM_SETTINGS - 1);
    localparam logic [3:0]    RST_IDX    = 4'(RESET_SETTING);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);

    // Scale must be a power of two so the coordinate divide reduces to a shift.
    if (!((SCALE == 1) || (SCALE == 2) || (SCALE == 4))) begin : g_bad_scale
        $error("timebase_label_renderer: SCALE must be 1, 2 or 4");
    end
    if ((NUM_SETTINGS < 1) || (NUM_SETTINGS > 16)) begin : g_bad_num
        $error("timebase_label_renderer: NUM_SETTINGS must be 1..16");
    end
    if ((RESET_SETTING < 0) || (RESET_SETTING >= NUM_SETTINGS)) begin : g_bad_rst
        $error("timebase_label_renderer: RESET_SETTING out of range");
    end

    logic [3:0]         r_pending;
    logic [3:0]         r_displayed;
    logic [FW-1:0]      r_flash;

    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic [31:0]        w_dx;
    logic [31:0]        w_dy;
    logic               w_in_region;
    logic [5:0]         w_u;
    logic [2:0]         w_slot;
    logic [2:0]         w_col;
    logic [3:0]         w_row;

    logic               r_s1_in;
    logic [2:0]         r_s1_slot;
    logic [2:0]         r_s1_col;
    logic [3:0]         r_s1_row;

    logic [3:0]         w_char;
    logic               w_font_bit;
    logic               r_pixel;

    assign w_x = bus.VGA_horzCoord;
    assign w_y = bus.VGA_vertCoord;

    // Step the pending setting on front-panel pulses; saturate at both ends, ignore simultaneous pulses.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_pending <= RST_IDX;
        end else if (bus.STEP_UP && !bus.STEP_DOWN) begin
            if (r_pending != MAX_IDX) r_pending <= r_pending + 4'd1;
        end else if (bus.STEP_DOWN && !bus.STEP_UP) begin
            if (r_pending != 4'd0) r_pending <= r_pending - 4'd1;
        end
    end

    // On each frame boundary show the pending setting; a change restarts the flash, otherwise it winds down.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_displayed <= RST_IDX;
            r_flash     <= '0;
        end else if (bus.FRAME_START) begin
            r_displayed <= r_pending;
            if (r_pending != r_displayed) begin
                r_flash <= FLASH_LOAD;
            end else if (r_flash != '0) begin
                r_flash <= r_flash - FW'(1);
            end
        end
    end

    // Region test is done at 32 bits so coordinates near the bus maximum never wrap into the label.
    assign w_in_region = (32'(w_x) >= 32'(X0)) && (32'(w_x) < 32'(X0 + REG_W)) &&
                         (32'(w_y) >= 32'(Y0)) && (32'(w_y) < 32'(Y0 + REG_H));
    assign w_dx = 32'(w_x) - 32'(X0);
    assign w_dy = 32'(w_y) - 32'(Y0);

    // Unscale the offset, then split into character slot, column within the cell and glyph row.
    always_comb begin
        w_u    = 6'(w_dx >> SH);
        w_slot = '0;
        w_col  = '0;
        w_row  = '0;
        if (w_in_region) begin
            w_slot = 3'(w_u / 6'd6);
            w_col  = 3'(w_u % 6'd6);
            w_row  = 4'(w_dy >> SH);
        end
    end

    // Stage 1: register the decoded cell position.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_s1_in   <= 1'b0;
            r_s1_slot <= '0;
            r_s1_col  <= '0;
            r_s1_row  <= '0;
        end else begin
            r_s1_in   <= w_in_region;
            r_s1_slot <= w_slot;
            r_s1_col  <= w_col;
            r_s1_row  <= w_row;
        end
    end

    // Look up the character for this slot from the label currently on screen.
    always_comb begin
        w_char = CH_SPACE;
        if (r_s1_slot < 3'(NUM_CELLS)) begin
            w_char = LABEL_TABLE[r_displayed][r_s1_slot];
        end
    end

    label_font_rom u_font (
        .i_char_code (w_char),
        .i_row       (r_s1_row),
        .i_col       (r_s1_col),
        .o_pixel     (w_font_bit)
    );

    // Stage 2: register the glyph pixel; the blank sixth column of each cell stays dark.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_pixel <= 1'b0;
        end else begin
            r_pixel <= r_s1_in && (r_s1_col < 3'(GLYPH_W)) && w_font_bit;
        end
    end

    assign bus.SETTING   = r_displayed;
    assign bus.PIXEL_ON  = r_pixel;
    assign bus.HIGHLIGHT = (r_flash != '0);

endmodule
